fir_input_ctrl: RTL and testbench
=================================

Name: fir_input_ctrl

Overview:
- Upstream stage of the 33-tap transposed FIR multiply/add/shift stage.
- Accepts input samples over a valid/ready handshake and drives that stage's sample input (oFirIn) and accumulate-enable strobe (oEnAcc).
- Owns the double-buffered coefficient bank: shadow written by address, active bank driven flat to the FIR stage.
- Coefficient swaps are atomic; samples are stalled during a swap.

Parameters:
- NUM_TAP, 33, number of coefficients (coefficient 1 maps to address 0).
- DATA_W, 16, sample and coefficient width, signed two's complement.
- ADDR_W, 6, coefficient address width; must satisfy 2^ADDR_W >= NUM_TAP.

Ports:
- iClk_12M  in  1  single system clock, 12 MHz.
- iRsn  in  1  asynchronous active-low reset.
- iCoeffWrEn  in  1  shadow-bank write strobe.
- iCoeffAddr  in  ADDR_W  shadow write address, 0..NUM_TAP-1.
- iCoeffData  in  DATA_W  shadow write data.
- iCoeffUpdate  in  1  request to copy shadow to active (one-cycle pulse).
- iSampleValid  in  1  upstream sample valid.
- iSampleData  in  DATA_W  upstream sample.
- oSampleReady  out  1  sample accepted when iSampleValid & oSampleReady.
- oFirIn  out  DATA_W  sample to FIR stage.
- oEnAcc  out  1  one-cycle accumulate/shift strobe to FIR stage.
- oCoeffFlat  out  NUM_TAP*DATA_W  active bank; coefficient k is at bits [k*DATA_W +: DATA_W].
- oUpdBusy  out  1  high in SWAP/FLUSH or while an update is pending.
- oCoeffErr  out  1  sticky out-of-range write flag.

Behaviour:
- Reset (async, iRsn=0):
  - Both banks are 0; oFirIn=0, oEnAcc=0, oUpdBusy=0, oCoeffErr=0.
  - oSampleReady=0 while in reset; state=RUN.
  - oSampleReady goes 1 on the first clock edge after reset deasserts.
- Reset mid-swap or mid-flush aborts the operation: banks are zeroed and any pending update is dropped.
- FSM states RUN, SWAP, FLUSH:
  - RUN: oSampleReady=1. An accepted iCoeffUpdate, or a pending flag, moves to SWAP on the next edge; oSampleReady drops in the same edge.
  - SWAP: lasts exactly 1 cycle. At its closing edge the active bank takes the whole shadow bank. Next state is FLUSH if FIR_FLUSH_ON_SWAP_EN is defined, else RUN.
  - FLUSH: lasts NUM_TAP cycles, counted by a 0..NUM_TAP-1 counter. oFirIn=0 and oEnAcc=1 every cycle. Returns to RUN after the count.
- Sample path:
  - A handshake at edge N gives oFirIn=iSampleData and oEnAcc=1 during cycle N+1, i.e. latency 1.
  - oEnAcc is 0 when there is no handshake.
  - oFirIn holds its last value outside handshake and flush cycles.
- A sample accepted in the same cycle as iCoeffUpdate is processed; its oEnAcc falls in the SWAP cycle, with the old active bank.
- Shadow writes:
  - Allowed in any state; take effect at the edge where iCoeffWrEn=1.
  - A write in the same cycle as iCoeffUpdate is included in the swap.
  - A write during SWAP lands in the shadow bank only. It is not copied by the swap in progress.
- Address checks:
  - iCoeffAddr >= NUM_TAP with iCoeffWrEn: the write is ignored and oCoeffErr is set.
  - oCoeffErr clears only on reset or on the SWAP closing edge.
- iCoeffUpdate while in SWAP/FLUSH sets a single pending flag; further requests merge into it. The pending request is serviced on the first RUN cycle.
- oUpdBusy = (state != RUN) | pending.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- FIR_FLUSH_ON_SWAP_EN defined: after each swap, NUM_TAP zero samples are fed so that no FIR output mixes old and new coefficients. Swap-to-ready latency is 1+NUM_TAP cycles.
- Not defined: the FLUSH state and its counter are not built. Ready returns 1 cycle after the swap; mixed-coefficient outputs are permitted.

Decomposition:
- fir_pkg:
  - constants FIR_NUM_TAP=33, FIR_DATA_W=16, FIR_ADDR_W=6;
  - FSM state encoding ST_RUN/ST_SWAP/ST_FLUSH.
- One sub-module, fir_coeff_bank:
  - holds the shadow and active register arrays, the write decode and the range check;
  - outputs the flat active bus;
  - inputs are the write port and a swap pulse.
- The FSM, handshake and flush counter stay in fir_input_ctrl.

Test Plan:
- Reset, then samples 0x0100, 0x0200 with valid held → oEnAcc pulses in the next 2 cycles; oFirIn=0x0100 then 0x0200; oCoeffFlat=0.
- Write addr 0=0x4000, addr 32=0x7FFF, then pulse iCoeffUpdate → after SWAP, oCoeffFlat[15:0]=0x4000 and [527:512]=0x7FFF; oSampleReady low for 1 cycle (flush off) or 34 cycles (flush on).
- With flush on, valid held high through an update → exactly 33 cycles of oEnAcc=1 with oFirIn=0; no samples lost; the next sample is emitted after the flush.
- Write addr 40 → oCoeffErr=1, bank unchanged; the next update clears oCoeffErr.
- iCoeffUpdate pulsed during FLUSH → oUpdBusy stays 1; a second SWAP starts on the first RUN cycle.
- Assert iRsn=0 mid-flush → all outputs 0 immediately, state RUN, pending update dropped.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR input controller.
package fir_pkg;

    localparam int FIR_NUM_TAP = 33;
    localparam int FIR_DATA_W  = 16;
    localparam int FIR_ADDR_W  = 6;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SWAP  = 2'd1,
        ST_FLUSH = 2'd2
    } fir_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int fir_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient bank: shadow written by address, active copied
// from shadow on a swap pulse and presented as a flat bus.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int NUM_TAP = FIR_NUM_TAP,
    parameter int DATA_W  = FIR_DATA_W,
    parameter int ADDR_W  = FIR_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      swap,
    output logic [NUM_TAP*DATA_W-1:0] coeff_flat,
    output logic                      coeff_err
);

    logic [DATA_W-1:0] shadow_r [NUM_TAP];
    logic [DATA_W-1:0] active_r [NUM_TAP];
    logic              in_range_s;
    logic              wr_ok_s;
    logic              wr_bad_s;
    logic              err_r;

    // One extra bit keeps the limit exact even when 2^ADDR_W equals NUM_TAP.
    assign in_range_s = ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_TAP));
    assign wr_ok_s    = wr_en & in_range_s;
    assign wr_bad_s   = wr_en & ~in_range_s;

    // Shadow bank: addressed writes, any FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAP; k++) shadow_r[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_TAP; k++) begin
                if (wr_ok_s && (wr_addr == ADDR_W'(k))) shadow_r[k] <= wr_data;
            end
        end
    end

    // Active bank: whole-bank copy takes the shadow contents from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAP; k++) active_r[k] <= '0;
        end else if (swap) begin
            for (int k = 0; k < NUM_TAP; k++) active_r[k] <= shadow_r[k];
        end
    end

    // Sticky range error; a new bad write wins over the swap clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (wr_bad_s) begin
            err_r <= 1'b1;
        end else if (swap) begin
            err_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_TAP; g++) begin : g_flat
        assign coeff_flat[g*DATA_W +: DATA_W] = active_r[g];
    end

    assign coeff_err = err_r;

endmodule

// File: rtl/fir_input_ctrl.sv
// Sample handshake, coefficient swap FSM and optional zero flush for the FIR stage.
// Define FIR_FLUSH_ON_SWAP_EN to feed NUM_TAP zero samples after every swap.
module fir_input_ctrl
    import fir_pkg::*;
#(
    parameter int NUM_TAP = FIR_NUM_TAP,
    parameter int DATA_W  = FIR_DATA_W,
    parameter int ADDR_W  = FIR_ADDR_W
) (
    input  logic                      iClk_12M,
    input  logic                      iRsn,
    input  logic                      iCoeffWrEn,
    input  logic [ADDR_W-1:0]         iCoeffAddr,
    input  logic [DATA_W-1:0]         iCoeffData,
    input  logic                      iCoeffUpdate,
    input  logic                      iSampleValid,
    input  logic [DATA_W-1:0]         iSampleData,
    output logic                      oSampleReady,
    output logic [DATA_W-1:0]         oFirIn,
    output logic                      oEnAcc,
    output logic [NUM_TAP*DATA_W-1:0] oCoeffFlat,
    output logic                      oUpdBusy,
    output logic                      oCoeffErr
);

    fir_state_e        state_r;
    fir_state_e        state_nxt_s;
    logic              pend_r;
    logic              pend_nxt_s;
    logic              ready_r;
    logic              busy_r;
    logic              en_acc_r;
    logic [DATA_W-1:0] fir_in_r;
    logic              hs_s;

`ifdef FIR_FLUSH_ON_SWAP_EN
    localparam int CNT_W = fir_cnt_w(NUM_TAP);
    logic [CNT_W-1:0] flush_cnt_r;
    logic             flush_last_s;

    assign flush_last_s = (flush_cnt_r == CNT_W'(NUM_TAP - 1));

    // Flush cycle counter, parked at zero outside FLUSH.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            flush_cnt_r <= '0;
        end else if ((state_r == ST_FLUSH) && !flush_last_s) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
        end else begin
            flush_cnt_r <= '0;
        end
    end
`endif

    assign hs_s = iSampleValid & ready_r;

    // Next state and pending-update merge.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        case (state_r)
            ST_RUN: begin
                pend_nxt_s = 1'b0;
                if (iCoeffUpdate || pend_r) begin
                    state_nxt_s = ST_SWAP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SWAP: begin
                pend_nxt_s = pend_r | iCoeffUpdate;
`ifdef FIR_FLUSH_ON_SWAP_EN
                state_nxt_s = ST_FLUSH;
`else
                state_nxt_s = ST_RUN;
`endif
            end
            ST_FLUSH: begin
                pend_nxt_s = pend_r | iCoeffUpdate;
`ifdef FIR_FLUSH_ON_SWAP_EN
                if (flush_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
`else
                state_nxt_s = ST_RUN;
`endif
            end
            default: begin
                state_nxt_s = ST_RUN;
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, pending flag and the status outputs derived from the next state.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_r <= ST_RUN;
            pend_r  <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            ready_r <= (state_nxt_s == ST_RUN);
            busy_r  <= (state_nxt_s != ST_RUN) | pend_nxt_s;
        end
    end

    // Sample path: flush zeros take priority; otherwise forward accepted samples.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            fir_in_r <= '0;
            en_acc_r <= 1'b0;
        end else if (state_nxt_s == ST_FLUSH) begin
            fir_in_r <= '0;
            en_acc_r <= 1'b1;
        end else if (hs_s) begin
            fir_in_r <= iSampleData;
            en_acc_r <= 1'b1;
        end else begin
            en_acc_r <= 1'b0;
        end
    end

    fir_coeff_bank #(
        .NUM_TAP (NUM_TAP),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_bank (
        .clk        (iClk_12M),
        .rst_n      (iRsn),
        .wr_en      (iCoeffWrEn),
        .wr_addr    (iCoeffAddr),
        .wr_data    (iCoeffData),
        .swap       (state_r == ST_SWAP),
        .coeff_flat (oCoeffFlat),
        .coeff_err  (oCoeffErr)
    );

    assign oSampleReady = ready_r;
    assign oFirIn       = fir_in_r;
    assign oEnAcc       = en_acc_r;
    assign oUpdBusy     = busy_r;

endmodule

// File: tb/tb_fir_input_ctrl.sv
// Self-checking bench for fir_input_ctrl: directed table, corner sequences and
// randomized traffic against a countdown-based reference model.
module tb_fir_input_ctrl;

    localparam int NT = 33;
    localparam int DW = 16;
    localparam int AW = 6;
`ifdef FIR_FLUSH_ON_SWAP_EN
    localparam int FLUSH_LEN = NT;
`else
    localparam int FLUSH_LEN = 0;
`endif
    localparam int WIN = 1 + FLUSH_LEN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             coeff_wr_en = 1'b0;
    logic [AW-1:0]    coeff_addr = '0;
    logic [DW-1:0]    coeff_data = '0;
    logic             coeff_update = 1'b0;
    logic             sample_valid = 1'b0;
    logic [DW-1:0]    sample_data = '0;
    logic             sample_ready;
    logic [DW-1:0]    fir_in;
    logic             en_acc;
    logic [NT*DW-1:0] coeff_flat;
    logic             upd_busy;
    logic             coeff_err;

    fir_input_ctrl dut (
        .iClk_12M     (clk),
        .iRsn         (rst_n),
        .iCoeffWrEn   (coeff_wr_en),
        .iCoeffAddr   (coeff_addr),
        .iCoeffData   (coeff_data),
        .iCoeffUpdate (coeff_update),
        .iSampleValid (sample_valid),
        .iSampleData  (sample_data),
        .oSampleReady (sample_ready),
        .oFirIn       (fir_in),
        .oEnAcc       (en_acc),
        .oCoeffFlat   (coeff_flat),
        .oUpdBusy     (upd_busy),
        .oCoeffErr    (coeff_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: m_left counts remaining non-ready cycles of a swap window
    // (first cycle is the swap itself, the rest are zero-flush cycles).
    logic [DW-1:0] m_shadow [NT];
    logic [DW-1:0] m_active [NT];
    logic          m_ready, m_enacc, m_busy, m_err, m_pend;
    logic [DW-1:0] m_firin;
    int            m_left;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_flat(input string nm, input logic [NT*DW-1:0] act, input logic [NT*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_ready = 1'b0; m_enacc = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_pend = 1'b0;
        m_firin = '0;   m_left = 0;
    endtask

    task automatic model_edge();
        logic hs, in_run, swap_now, new_pend;
        int   new_left, idx;
        hs       = sample_valid && m_ready;
        in_run   = (m_left == 0);
        swap_now = (m_left == WIN);
        new_left = in_run ? ((coeff_update || m_pend) ? WIN : 0) : m_left - 1;
        new_pend = in_run ? 1'b0 : (m_pend || coeff_update);
        if (swap_now) begin
            for (int k = 0; k < NT; k++) m_active[k] = m_shadow[k];
            m_err = 1'b0;
        end
        if (coeff_wr_en) begin
            idx = int'(coeff_addr);
            if (idx < NT) m_shadow[idx] = coeff_data;
            else m_err = 1'b1;
        end
        if (new_left > 0 && new_left < WIN) begin
            m_firin = '0;
            m_enacc = 1'b1;
        end else if (hs) begin
            m_firin = sample_data;
            m_enacc = 1'b1;
        end else begin
            m_enacc = 1'b0;
        end
        m_left  = new_left;
        m_pend  = new_pend;
        m_ready = (new_left == 0);
        m_busy  = (new_left != 0) || new_pend;
    endtask

    function automatic logic [NT*DW-1:0] model_flat();
        logic [NT*DW-1:0] f;
        for (int k = 0; k < NT; k++) f[k*DW +: DW] = m_active[k];
        return f;
    endfunction

    task automatic check_all();
        chk("ready", 64'(sample_ready), 64'(m_ready));
        chk("fir_in", 64'(fir_in), 64'(m_firin));
        chk("en_acc", 64'(en_acc), 64'(m_enacc));
        chk("busy", 64'(upd_busy), 64'(m_busy));
        chk("err", 64'(coeff_err), 64'(m_err));
        chk_flat("flat", coeff_flat, model_flat());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) model_edge();
        check_all();
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] d, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic u);
        sample_valid = v; sample_data = d; coeff_wr_en = w;
        coeff_addr = a;   coeff_data = wd; coeff_update = u;
    endtask

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] data;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic          upd;
        logic          e_rdy;
        logic          e_en;
        logic [DW-1:0] e_fir;
        logic          e_err;
    } vec_t;

    vec_t             tbl [8];
    logic [DW-1:0]    accq [$];
    logic [DW-1:0]    exp_d;
    int               lowcnt, zcnt, bc, guard;

    initial begin
        tbl[0] = '{vld:1'b0, data:16'h0000, wr:1'b0, addr:6'd0,  wdat:16'h0000, upd:1'b0, e_rdy:1'b1, e_en:1'b0, e_fir:16'h0000, e_err:1'b0};
        tbl[1] = '{vld:1'b1, data:16'h0100, wr:1'b0, addr:6'd0,  wdat:16'h0000, upd:1'b0, e_rdy:1'b1, e_en:1'b1, e_fir:16'h0100, e_err:1'b0};
        tbl[2] = '{vld:1'b1, data:16'h0200, wr:1'b0, addr:6'd0,  wdat:16'h0000, upd:1'b0, e_rdy:1'b1, e_en:1'b1, e_fir:16'h0200, e_err:1'b0};
        tbl[3] = '{vld:1'b0, data:16'h0000, wr:1'b0, addr:6'd0,  wdat:16'h0000, upd:1'b0, e_rdy:1'b1, e_en:1'b0, e_fir:16'h0200, e_err:1'b0};
        tbl[4] = '{vld:1'b0, data:16'h0000, wr:1'b1, addr:6'd40, wdat:16'h1234, upd:1'b0, e_rdy:1'b1, e_en:1'b0, e_fir:16'h0200, e_err:1'b1};
        tbl[5] = '{vld:1'b0, data:16'h0000, wr:1'b1, addr:6'd0,  wdat:16'h4000, upd:1'b0, e_rdy:1'b1, e_en:1'b0, e_fir:16'h0200, e_err:1'b1};
        tbl[6] = '{vld:1'b1, data:16'h0300, wr:1'b1, addr:6'd32, wdat:16'h7FFF, upd:1'b0, e_rdy:1'b1, e_en:1'b1, e_fir:16'h0300, e_err:1'b1};
        tbl[7] = '{vld:1'b0, data:16'h0000, wr:1'b0, addr:6'd0,  wdat:16'h0000, upd:1'b0, e_rdy:1'b1, e_en:1'b0, e_fir:16'h0300, e_err:1'b1};

        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst ready", 64'(sample_ready), 64'd0);
        chk("rst en_acc", 64'(en_acc), 64'd0);
        chk("rst fir_in", 64'(fir_in), 64'd0);
        chk("rst busy", 64'(upd_busy), 64'd0);
        chk("rst err", 64'(coeff_err), 64'd0);
        chk_flat("rst flat", coeff_flat, '0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Directed table: samples, out-of-range write, shadow writes.
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].vld, tbl[i].data, tbl[i].wr, tbl[i].addr, tbl[i].wdat, tbl[i].upd);
            tick();
            chk($sformatf("tbl%0d ready", i), 64'(sample_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d en_acc", i), 64'(en_acc), 64'(tbl[i].e_en));
            chk($sformatf("tbl%0d fir_in", i), 64'(fir_in), 64'(tbl[i].e_fir));
            chk($sformatf("tbl%0d err", i), 64'(coeff_err), 64'(tbl[i].e_err));
            chk_flat($sformatf("tbl%0d flat", i), coeff_flat, '0);
        end

        // Swap: ready low for the window, new bank visible, error cleared.
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        coeff_update = 1'b0;
        chk("swap ready drop", 64'(sample_ready), 64'd0);
        chk("swap busy", 64'(upd_busy), 64'd1);
        lowcnt = 1; zcnt = 0; guard = 0;
        while (!sample_ready && guard < 200) begin
            tick();
            guard++;
            if (en_acc && fir_in == '0) zcnt++;
            if (!sample_ready) lowcnt++;
        end
        chk("swap low cycles", 64'(lowcnt), 64'(WIN));
        chk("swap flush zeros", 64'(zcnt), 64'(FLUSH_LEN));
        chk("swap coeff0", 64'(coeff_flat[15:0]), 64'h4000);
        chk("swap coeff32", 64'(coeff_flat[527:512]), 64'h7FFF);
        chk("swap err clr", 64'(coeff_err), 64'd0);
        chk("swap busy done", 64'(upd_busy), 64'd0);

        // Valid held through an update: no sample lost, flush zeros in between.
        zcnt = 0;
        for (int i = 0; i < 60; i++) begin
            set_in(i < 50, 16'h0A00 + 16'(i), 1'b0, '0, '0, i == 2);
            if (sample_valid && m_ready) accq.push_back(sample_data);
            tick();
            if (en_acc) begin
                if (fir_in == '0) begin
                    zcnt++;
                end else if (accq.size() > 0) begin
                    exp_d = accq.pop_front();
                    chk("hold order", 64'(fir_in), 64'(exp_d));
                end else begin
                    chk("hold extra sample", 64'(fir_in), 64'd0);
                end
            end
        end
        chk("hold flush zeros", 64'(zcnt), 64'(FLUSH_LEN));
        chk("hold all emitted", 64'(accq.size()), 64'd0);

        // Update during the last busy cycle: pending merges, second swap follows.
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        coeff_update = 1'b0;
        bc = int'(upd_busy);
        for (int i = 1; i < WIN; i++) begin
            tick();
            bc += int'(upd_busy);
        end
        coeff_update = 1'b1;
        tick();
        coeff_update = 1'b0;
        bc += int'(upd_busy);
        guard = 0;
        while (upd_busy && guard < 300) begin
            tick();
            guard++;
            bc += int'(upd_busy);
        end
        chk("pend busy cycles", 64'(bc), 64'(2 * WIN + 1));

        // Reset in the middle of a window with an update pending.
        set_in(1'b0, '0, 1'b1, 6'd5, 16'h5555, 1'b1);
        tick();
        coeff_wr_en = 1'b0;
        tick();
        coeff_update = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid rst ready", 64'(sample_ready), 64'd0);
        chk("mid rst en_acc", 64'(en_acc), 64'd0);
        chk("mid rst fir_in", 64'(fir_in), 64'd0);
        chk("mid rst busy", 64'(upd_busy), 64'd0);
        chk_flat("mid rst flat", coeff_flat, '0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst ready", 64'(sample_ready), 64'd1);
        tick();
        chk("post rst no swap", 64'(upd_busy), 64'd0);
        chk("post rst ready2", 64'(sample_ready), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 3,
                   6'($urandom_range(0, 63)), 16'($urandom), $urandom_range(0, 39) == 0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b0);
        repeat (WIN + 2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
